// File: rtl/alu_shift_sched_pkg.sv
// Shared constants for the shift-unit scheduler: field widths and COASZP flag bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_shift_sched_pkg;

  // Default geometry of the scheduler.
  localparam int NPORT_DEF = 3;
  localparam int PORT_W    = $clog2(NPORT_DEF);
  localparam int OP_W      = 5;
  localparam int TAG_W     = 6;
  localparam int FLG_W     = 6;

  // Bit positions of the COASZP flag vector returned by the shifter.
  localparam int FLG_C = 5;
  localparam int FLG_O = 4;
  localparam int FLG_A = 3;
  localparam int FLG_S = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_P = 0;

endpackage

// File: rtl/alu_shift_sched_if.sv
// Bundle between issue ports, the shift datapath and the shift-unit scheduler.
// Latency: n/a (wires only).
// Backpressure: sh_busy from the datapath blocks every grant; req_vld is held until req_gnt.
// Ports: except/except_thread flush strobe; req_* per-port requests; req_gnt one-hot grant;
//        sh_* shifter issue; flg_in shifter flags; flg_* flag return to the winning port.
interface alu_shift_sched_if
  import alu_shift_sched_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int OPW   = OP_W,
  parameter int TAGW  = TAG_W
);

  logic                  except;
  logic                  except_thread;
  logic [NPORT-1:0]      req_vld;
  logic [NPORT-1:0]      req_thread;
  logic [NPORT*OPW-1:0]  req_op;
  logic [NPORT*TAGW-1:0] req_tag;
  logic                  sh_busy;
  logic [NPORT-1:0]      req_gnt;
  logic                  sh_vld;
  logic [OPW-1:0]        sh_operation;
  logic [PORT_W-1:0]     sh_sel;
  logic [FLG_W-1:0]      flg_in;
  logic                  flg_vld;
  logic [FLG_W-1:0]      flg_out;
  logic [TAGW-1:0]       flg_tag;
  logic [PORT_W-1:0]     flg_port;

  // Scheduler side.
  modport slave (
    input  except, except_thread, req_vld, req_thread, req_op, req_tag, sh_busy, flg_in,
    output req_gnt, sh_vld, sh_operation, sh_sel, flg_vld, flg_out, flg_tag, flg_port
  );

  // Issue-port / datapath side.
  modport master (
    output except, except_thread, req_vld, req_thread, req_op, req_tag, sh_busy, flg_in,
    input  req_gnt, sh_vld, sh_operation, sh_sel, flg_vld, flg_out, flg_tag, flg_port
  );

endinterface

// File: rtl/alu_shift_sched_rr_arb_onehot.sv
// Round-robin arbiter: first set request scanning from ptr upward, wrapping mod NPORT.
// Latency: combinational.
// Backpressure: none; masking of requests is the caller's job.
// Ports: req (request vector), ptr (start index) -> gnt (one-hot), idx (encoded), any (some grant).
module alu_shift_sched_rr_arb_onehot #(
  parameter int NPORT = 3,
  parameter int PW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  // Index reached k steps after p, wrapping at NPORT (p is always < NPORT).
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NPORT) s = s - NPORT;
    return PW'(s);
  endfunction

  // Scan from the farthest offset back to ptr so the nearest requester wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr, k)]) begin
        any = 1'b1;
        idx = rot_idx(ptr, k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NPORT; i++) begin
      gnt[i] = any && (idx == PW'(i));
    end
  end

endmodule

// File: rtl/alu_shift_sched.sv
// Shift-unit scheduler: round-robin grant of one shifter among NPORT issue ports, returns flags to the winner's tag.
// Latency: grant/issue same cycle as request; flags and tag returned one cycle after issue.
// Backpressure: sh_busy or a same-thread exception suppresses the grant; losers hold req_vld.
// Ports: clk, rst (sync active-high), bus (slave side of alu_shift_sched_if).
module alu_shift_sched
  import alu_shift_sched_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int OPW   = OP_W,
  parameter int TAGW  = TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  alu_shift_sched_if.slave   bus
);

  logic [NPORT-1:0]  elig;
  logic [NPORT-1:0]  gnt;
  logic [PORT_W-1:0] gnt_idx;
  logic              gnt_any;
  logic [PORT_W-1:0] rr_ptr;

  logic              s1_vld;
  logic [TAGW-1:0]   s1_tag;
  logic              s1_thread;
  logic [PORT_W-1:0] s1_port;

  // A port competes only if the shifter input is free, it is not being flushed,
  // and reset is not asserted (reset dominates every input).
  always_comb begin
    elig = '0;
    for (int i = 0; i < NPORT; i++) begin
      elig[i] = bus.req_vld[i] & ~bus.sh_busy & ~rst
              & ~(bus.except & (bus.req_thread[i] == bus.except_thread));
    end
  end

  alu_shift_sched_rr_arb_onehot #(
    .NPORT (NPORT),
    .PW    (PORT_W)
  ) u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign bus.req_gnt      = gnt;
  assign bus.sh_vld       = gnt_any;
  assign bus.sh_operation = gnt_any ? bus.req_op[gnt_idx*OPW +: OPW] : '0;
  assign bus.sh_sel       = gnt_any ? gnt_idx : '0;

  // Stage 1 remembers who issued so the flags arriving next cycle can be routed back.
  // A new grant simply overwrites it: the previous op's flags are on flg_in this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      s1_vld    <= 1'b0;
      s1_tag    <= '0;
      s1_thread <= 1'b0;
      s1_port   <= '0;
    end else begin
      s1_vld <= gnt_any;
      if (gnt_any) begin
        rr_ptr    <= (gnt_idx == PORT_W'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
        s1_tag    <= bus.req_tag[gnt_idx*TAGW +: TAGW];
        s1_thread <= bus.req_thread[gnt_idx];
        s1_port   <= gnt_idx;
      end
    end
  end

  // The flag return is killed if its thread is flushed in the cycle the flags arrive.
  assign bus.flg_vld  = s1_vld & ~rst & ~(bus.except & (s1_thread == bus.except_thread));
  assign bus.flg_out  = rst ? '0 : bus.flg_in;
  assign bus.flg_tag  = s1_tag;
  assign bus.flg_port = s1_port;

endmodule

// File: tb/tb_alu_shift_sched.sv
module tb_alu_shift_sched;
  import alu_shift_sched_pkg::*;

  localparam logic [OP_W-1:0] OP_SHL = 5'd3;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_shift_sched_if #(.NPORT(3), .OPW(OP_W), .TAGW(TAG_W)) bus ();

  alu_shift_sched #(.NPORT(3), .OPW(OP_W), .TAGW(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.except        = 1'b0;
    bus.except_thread = 1'b0;
    bus.req_vld       = '0;
    bus.req_thread    = '0;
    bus.req_op        = '0;
    bus.req_tag       = '0;
    bus.sh_busy       = 1'b0;
    bus.flg_in        = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.req_vld = 3'b111;
    bus.flg_in  = 6'h3f;
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b want 000", bus.req_gnt); end
    checks++; if (bus.sh_vld !== 1'b0) begin errors++; $display("FAIL rst_sh_vld: got %b want 0", bus.sh_vld); end
    checks++; if (bus.flg_vld !== 1'b0) begin errors++; $display("FAIL rst_flg_vld: got %b want 0", bus.flg_vld); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.flg_tag !== 6'd0) begin errors++; $display("FAIL rst_flg_tag: got %0d want 0", bus.flg_tag); end
    checks++; if (bus.flg_port !== 2'd0) begin errors++; $display("FAIL rst_flg_port: got %0d want 0", bus.flg_port); end
    checks++; if (bus.flg_out !== 6'd0) begin errors++; $display("FAIL rst_flg_out: got %b want 0", bus.flg_out); end
    checks++; if (bus.sh_operation !== 5'd0) begin errors++; $display("FAIL rst_sh_op: got %0d want 0", bus.sh_operation); end
    step();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_issue();
    bus.req_vld    = 3'b001;
    bus.req_thread = 3'b000;
    bus.req_op     = {5'd0, 5'd0, OP_SHL};
    bus.req_tag    = {6'd0, 6'd0, 6'd5};
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", bus.req_gnt); end
    checks++; if (bus.sh_vld !== 1'b1) begin errors++; $display("FAIL single_sh_vld: got %b want 1", bus.sh_vld); end
    checks++; if (bus.sh_operation !== OP_SHL) begin errors++; $display("FAIL single_sh_op: got %0d want %0d", bus.sh_operation, OP_SHL); end
    checks++; if (bus.sh_sel !== 2'd0) begin errors++; $display("FAIL single_sh_sel: got %0d want 0", bus.sh_sel); end
    step();
    bus.req_vld = 3'b000;
    bus.flg_in  = 6'b100101;
    @(negedge clk);
    checks++; if (bus.flg_vld !== 1'b1) begin errors++; $display("FAIL single_flg_vld: got %b want 1", bus.flg_vld); end
    checks++; if (bus.flg_tag !== 6'd5) begin errors++; $display("FAIL single_flg_tag: got %0d want 5", bus.flg_tag); end
    checks++; if (bus.flg_port !== 2'd0) begin errors++; $display("FAIL single_flg_port: got %0d want 0", bus.flg_port); end
    checks++; if (bus.flg_out !== 6'b100101) begin errors++; $display("FAIL single_flg_out: got %b want 100101", bus.flg_out); end
    checks++; if (bus.sh_vld !== 1'b0) begin errors++; $display("FAIL single_idle_sh_vld: got %b want 0", bus.sh_vld); end
    checks++; if (bus.sh_operation !== 5'd0) begin errors++; $display("FAIL single_idle_sh_op: got %0d want 0", bus.sh_operation); end
    step();
    bus.flg_in = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] eg;
    logic [1:0] es;
    logic [4:0] eo;
    logic [5:0] et;
    do_reset();
    bus.req_vld = 3'b111;
    bus.req_op  = {5'd3, 5'd2, 5'd1};
    bus.req_tag = {6'd30, 6'd20, 6'd10};
    for (int k = 0; k < 6; k++) begin
      eg = 3'b001 << (k % 3);
      es = 2'(k % 3);
      eo = 5'((k % 3) + 1);
      @(negedge clk);
      checks++; if (bus.req_gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.req_gnt, eg); end
      checks++; if (bus.sh_sel !== es) begin errors++; $display("FAIL rr_sh_sel[%0d]: got %0d want %0d", k, bus.sh_sel, es); end
      checks++; if (bus.sh_operation !== eo) begin errors++; $display("FAIL rr_sh_op[%0d]: got %0d want %0d", k, bus.sh_operation, eo); end
      if (k > 0) begin
        et = 6'(((k - 1) % 3) * 10 + 10);
        checks++; if (bus.flg_vld !== 1'b1) begin errors++; $display("FAIL rr_flg_vld[%0d]: got %b want 1", k, bus.flg_vld); end
        checks++; if (bus.flg_tag !== et) begin errors++; $display("FAIL rr_flg_tag[%0d]: got %0d want %0d", k, bus.flg_tag, et); end
      end
      step();
    end
    bus.req_vld = 3'b000;
    @(negedge clk);
    checks++; if (bus.flg_tag !== 6'd30) begin errors++; $display("FAIL rr_last_tag: got %0d want 30", bus.flg_tag); end
    checks++; if (bus.flg_port !== 2'd2) begin errors++; $display("FAIL rr_last_port: got %0d want 2", bus.flg_port); end
    step();
  endtask

  task automatic test_busy();
    bus.req_vld = 3'b101;
    bus.sh_busy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.req_gnt !== 3'b000) begin errors++; $display("FAIL busy_gnt[%0d]: got %b want 000", k, bus.req_gnt); end
      checks++; if (bus.sh_vld !== 1'b0) begin errors++; $display("FAIL busy_sh_vld[%0d]: got %b want 0", k, bus.sh_vld); end
      step();
    end
    bus.sh_busy = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b001) begin errors++; $display("FAIL busy_after_gnt: got %b want 001", bus.req_gnt); end
    checks++; if (bus.flg_vld !== 1'b0) begin errors++; $display("FAIL busy_flg_vld: got %b want 0", bus.flg_vld); end
    step();
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b100) begin errors++; $display("FAIL busy_next_gnt: got %b want 100", bus.req_gnt); end
    step();
    bus.req_vld = 3'b000;
  endtask

  task automatic test_except_flags();
    bus.req_vld    = 3'b010;
    bus.req_thread = 3'b010;
    bus.req_tag    = {6'd0, 6'd7, 6'd0};
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b010) begin errors++; $display("FAIL exf_gnt_a: got %b want 010", bus.req_gnt); end
    step();
    bus.req_vld       = 3'b000;
    bus.except        = 1'b1;
    bus.except_thread = 1'b1;
    @(negedge clk);
    checks++; if (bus.flg_vld !== 1'b0) begin errors++; $display("FAIL exf_same_thread_flg_vld: got %b want 0", bus.flg_vld); end
    step();
    bus.except  = 1'b0;
    bus.req_vld = 3'b010;
    bus.req_tag = {6'd0, 6'd9, 6'd0};
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b010) begin errors++; $display("FAIL exf_gnt_b: got %b want 010", bus.req_gnt); end
    step();
    bus.req_vld       = 3'b000;
    bus.except        = 1'b1;
    bus.except_thread = 1'b0;
    @(negedge clk);
    checks++; if (bus.flg_vld !== 1'b1) begin errors++; $display("FAIL exf_other_thread_flg_vld: got %b want 1", bus.flg_vld); end
    checks++; if (bus.flg_tag !== 6'd9) begin errors++; $display("FAIL exf_other_thread_tag: got %0d want 9", bus.flg_tag); end
    step();
    bus.except = 1'b0;
  endtask

  task automatic test_except_issue();
    bus.except        = 1'b1;
    bus.except_thread = 1'b0;
    bus.req_vld       = 3'b011;
    bus.req_thread    = 3'b010;
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b010) begin errors++; $display("FAIL exi_gnt: got %b want 010", bus.req_gnt); end
    checks++; if (bus.sh_sel !== 2'd1) begin errors++; $display("FAIL exi_sh_sel: got %0d want 1", bus.sh_sel); end
    step();
    bus.except  = 1'b0;
    bus.req_vld = 3'b000;
    @(negedge clk);
    checks++; if (bus.flg_vld !== 1'b1) begin errors++; $display("FAIL exi_flg_vld: got %b want 1", bus.flg_vld); end
    checks++; if (bus.flg_port !== 2'd1) begin errors++; $display("FAIL exi_flg_port: got %0d want 1", bus.flg_port); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.req_vld    = 3'b001;
    bus.req_thread = 3'b000;
    bus.req_op     = {5'd0, 5'd0, OP_SHL};
    bus.req_tag    = {6'd0, 6'd0, 6'd12};
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b001) begin errors++; $display("FAIL rmid_gnt: got %b want 001", bus.req_gnt); end
    step();
    bus.req_vld = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.flg_vld !== 1'b0) begin errors++; $display("FAIL rmid_flg_vld_in_rst: got %b want 0", bus.flg_vld); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.flg_vld !== 1'b0) begin errors++; $display("FAIL rmid_flg_vld: got %b want 0", bus.flg_vld); end
    checks++; if (bus.flg_tag !== 6'd0) begin errors++; $display("FAIL rmid_flg_tag: got %0d want 0", bus.flg_tag); end
    checks++; if (bus.flg_port !== 2'd0) begin errors++; $display("FAIL rmid_flg_port: got %0d want 0", bus.flg_port); end
    checks++; if (bus.req_gnt !== 3'b000) begin errors++; $display("FAIL rmid_gnt_idle: got %b want 000", bus.req_gnt); end
    checks++; if (bus.sh_vld !== 1'b0) begin errors++; $display("FAIL rmid_sh_vld: got %b want 0", bus.sh_vld); end
    step();
    bus.req_vld = 3'b111;
    @(negedge clk);
    checks++; if (bus.req_gnt !== 3'b001) begin errors++; $display("FAIL rmid_ptr_gnt: got %b want 001", bus.req_gnt); end
    step();
    bus.req_vld = 3'b000;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_issue();
    test_round_robin();
    test_busy();
    test_except_flags();
    test_except_issue();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
